puf_response_ctrl: RTL and testbench
====================================

Name: puf_response_ctrl

Overview:
- Measurement controller for the ring-oscillator PUF array. It drives the two oscillator-bank select buses and the enable and clear controls for the two edge counters.
- It captures both 16-bit counts after a fixed gate window and compares them, producing one response bit per oscillator pair.
- It assembles RESP_BITS bits into a response word, delivered on a valid/ready handshake.
- It sits directly upstream of the counter banks (drives them) and downstream of them (consumes their counts).

Parameters:
- RESP_BITS, 8, response bits per challenge (1..16).
- WINDOW, 1024, gate cycles with osc_en high (1..65535).
- CLR_CYCLES, 2, cycles cnt_clr is held before each gate (>=1).
- SETTLE, 4, cycles after the gate before counts are sampled; covers counter ripple and synchronisers (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset rst_n, asynchronous, active-high.
- start, input, 1, pulse or level; sampled only in IDLE.
- challenge, input, 8, captured on accepted start.
- count_a, input, 16, bank-A counter value, stable in SETTLE/COMPARE.
- count_b, input, 16, bank-B counter value.
- sel_a, output, 4, bank-A oscillator select.
- sel_b, output, 4, bank-B oscillator select.
- osc_en, output, 1, oscillator enable (high only in GATE).
- cnt_clr, output, 1, counter clear (high only in CLEAR).
- busy, output, 1, high in every state except IDLE.
- resp_data, output, RESP_BITS, response word.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, consumer accepts.
- tie_cnt, output, 5, number of pairs with count_a == count_b in this response.
- sat_flag, output, 1, any sampled count == 16'hFFFF in this response.

Behaviour:
- Reset (async): state IDLE; sel_a=sel_b=0; osc_en=0; cnt_clr=0; busy=0; resp_data=0; resp_valid=0; tie_cnt=0; sat_flag=0; bit index k=0; timer=0.
- IDLE → CLEAR when start=1.
  - Latch challenge into chal_q. Clear resp_data, tie_cnt, sat_flag; k=0.
- Pair selection, registered and held constant from CLEAR through COMPARE:
  - sel_a = (chal_q[3:0] + k) mod 16.
  - off = (chal_q[7:4]==0) ? 1 : chal_q[7:4].
  - sel_b = (sel_a + off) mod 16. This guarantees sel_a != sel_b.
- CLEAR: cnt_clr=1 for CLR_CYCLES cycles, then → GATE.
- GATE: osc_en=1 for exactly WINDOW cycles, then → SETTLE. The timer is 16-bit and reloads on each state entry.
- SETTLE: osc_en=0 for SETTLE cycles, then → COMPARE.
- COMPARE, 1 cycle:
  - resp_data[k] = (count_a > count_b), unsigned compare.
  - Tie (equal): bit=0 and tie_cnt += 1.
  - Either count == 16'hFFFF: sat_flag=1 (sticky until the next start).
  - If k == RESP_BITS-1 → DONE; else k += 1 → CLEAR.
- DONE: resp_valid=1. resp_data, tie_cnt and sat_flag are stable while valid.
  - Transfer occurs on a cycle with resp_valid && resp_ready; next cycle resp_valid=0 → IDLE.
  - resp_valid must not drop before the transfer.
- start outside IDLE is ignored (no queuing). start held high in IDLE after a transfer begins a new run the next cycle.
- Latency from start to resp_valid = 1 + RESP_BITS*(CLR_CYCLES+WINDOW+SETTLE+1) cycles.
  - Defaults: 1 + 8*1031 = 8249.
- Reset asserted mid-run: immediate return to reset values; osc_en and cnt_clr drop asynchronously; any partial response is discarded.
- osc_en and cnt_clr are never high in the same cycle.

Test Plan:
- Default params, challenge=8'h30, count_a=500, count_b=400 for all pairs:
  - sel pairs (0,3),(1,4)..(7,10).
  - resp_data=8'hFF, tie_cnt=0, resp_valid at cycle 8249 after start.
- challenge=8'h0E (off forced to 1), count_a<count_b:
  - sel_a wraps 14,15,0,1..; sel_b = sel_a+1 mod 16.
  - resp_data=8'h00.
- count_a==count_b==1234 on pairs k=2 and k=5, count_a>count_b otherwise:
  - resp_data=8'hDB, tie_cnt=2.
- count_b=16'hFFFF on one pair:
  - that bit=0, sat_flag=1.
  - sat_flag clears on the next accepted start.
- resp_ready held low 50 cycles after valid:
  - resp_valid and data stable throughout; transfer on ready; IDLE next cycle.
  - start pulses during busy are ignored.
- rst_n pulsed during GATE of pair k=3:
  - all outputs return to reset values within the same cycle.
  - A later start yields a full, correct response.

Source files
------------

// File: rtl/puf_response_ctrl.sv
// puf_response_ctrl
// Measurement sequencer for a ring-oscillator PUF. For each response bit it
// picks an oscillator pair, clears the two edge counters, gates the
// oscillators for a fixed window, lets the counters settle, and then compares
// the two counts. RESP_BITS such bits are packed into one response word,
// which is offered on a valid/ready handshake.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-high reset
//   start, challenge    : begin a measurement run (accepted only when idle)
//   count_a, count_b    : counter bank values, stable during SETTLE/COMPARE
//   sel_a, sel_b        : oscillator selects for bank A / bank B
//   osc_en, cnt_clr     : oscillator gate and counter clear
//   busy                : run in progress (any state other than IDLE)
//   resp_data/valid/ready : response word handshake
//   tie_cnt, sat_flag   : number of equal-count pairs, any saturated count
module puf_response_ctrl #(
  parameter int RESP_BITS  = 8,
  parameter int WINDOW     = 1024,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           challenge,
  input  logic [15:0]          count_a,
  input  logic [15:0]          count_b,
  output logic [3:0]           sel_a,
  output logic [3:0]           sel_b,
  output logic                 osc_en,
  output logic                 cnt_clr,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [4:0]           tie_cnt,
  output logic                 sat_flag
);

  localparam int            KW     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(RESP_BITS - 1);
  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [15:0]   T_CLR  = 16'(CLR_CYCLES - 1);
  localparam logic [15:0]   T_WIN  = 16'(WINDOW - 1);
  localparam logic [15:0]   T_SET  = 16'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [15:0]          r_timer;
  logic [15:0]          w_timer_load;
  logic [KW-1:0]        r_k;
  logic [3:0]           r_sel_a;
  logic [3:0]           r_sel_b;
  logic [RESP_BITS-1:0] r_resp_data;
  logic [4:0]           r_tie_cnt;
  logic                 r_sat_flag;

  logic                 w_accept;
  logic                 w_bit;
  logic                 w_tie;
  logic                 w_sat;
  logic                 w_last;
  logic [3:0]           w_off;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_bit    = (count_a > count_b);
  assign w_tie    = (count_a == count_b);
  assign w_sat    = (count_a == 16'hFFFF) || (count_b == 16'hFFFF);
  assign w_last   = (r_k == K_LAST);
  // A zero offset would select the same oscillator twice; force it to 1.
  assign w_off    = (challenge[7:4] == 4'd0) ? 4'd1 : challenge[7:4];

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, timer reload and control outputs
  always_comb begin
    w_state_next = r_state;
    w_timer_load = 16'd0;
    osc_en       = 1'b0;
    cnt_clr      = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = S_CLEAR;
          w_timer_load = T_CLR;
        end
      end
      S_CLEAR: begin
        cnt_clr = 1'b1;
        if (r_timer == 16'd0) begin
          w_state_next = S_GATE;
          w_timer_load = T_WIN;
        end
      end
      S_GATE: begin
        osc_en = 1'b1;
        if (r_timer == 16'd0) begin
          w_state_next = S_SETTLE;
          w_timer_load = T_SET;
        end
      end
      S_SETTLE: begin
        if (r_timer == 16'd0) begin
          w_state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CLEAR;
          w_timer_load = T_CLR;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Phase timer, pair selection and response accumulation
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_timer     <= 16'd0;
      r_k         <= '0;
      r_sel_a     <= 4'd0;
      r_sel_b     <= 4'd0;
      r_resp_data <= '0;
      r_tie_cnt   <= 5'd0;
      r_sat_flag  <= 1'b0;
    end else begin
      // Reload on every state change, otherwise count down to zero.
      if (w_state_next != r_state) begin
        r_timer <= w_timer_load;
      end else if (r_timer != 16'd0) begin
        r_timer <= r_timer - 16'd1;
      end

      if (w_accept) begin
        r_k         <= '0;
        r_sel_a     <= challenge[3:0];
        r_sel_b     <= challenge[3:0] + w_off;
        r_resp_data <= '0;
        r_tie_cnt   <= 5'd0;
        r_sat_flag  <= 1'b0;
      end

      if (r_state == S_COMPARE) begin
        r_resp_data[r_k] <= w_bit;
        if (w_tie) begin
          r_tie_cnt <= r_tie_cnt + 5'd1;
        end
        if (w_sat) begin
          r_sat_flag <= 1'b1;
        end
        // Both selects advance together, so the pair offset is preserved
        // and the mod-16 wrap falls out of the 4-bit adders.
        if (!w_last) begin
          r_k     <= r_k + 1'b1;
          r_sel_a <= r_sel_a + 4'd1;
          r_sel_b <= r_sel_b + 4'd1;
        end
      end
    end
  end

  assign sel_a     = r_sel_a;
  assign sel_b     = r_sel_b;
  assign resp_data = r_resp_data;
  assign tie_cnt   = r_tie_cnt;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_puf_response_ctrl.sv
// Testbench for puf_response_ctrl (default parameters). A table-driven
// counter-bank model supplies count_a/count_b per pair index; expected
// responses and oscillator pairs are queued when a run is started and
// compared as the DUT gates each pair and hands over each response.
module tb_puf_response_ctrl;

  localparam int LAT = 1 + 8 * (2 + 1024 + 4 + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  challenge = 8'd0;
  logic        resp_ready = 1'b1;
  logic [15:0] count_a;
  logic [15:0] count_b;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic        osc_en;
  logic        cnt_clr;
  logic        busy;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic [4:0]  tie_cnt;
  logic        sat_flag;

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] tie;
    logic       sat;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  sel_q[$];
  logic [15:0] ca_tab[16];
  logic [15:0] cb_tab[16];
  logic [3:0]  cur_base = 4'd0;
  logic        osc_prev = 1'b0;
  resp_t       mon_resp;
  logic [7:0]  mon_sel;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // Counter bank model: counts depend on which pair index is selected.
  assign count_a = ca_tab[4'(sel_a - cur_base)];
  assign count_b = cb_tab[4'(sel_a - cur_base)];

  puf_response_ctrl #(
    .RESP_BITS (8),
    .WINDOW    (1024),
    .CLR_CYCLES(2),
    .SETTLE    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .challenge (challenge),
    .count_a   (count_a),
    .count_b   (count_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .osc_en    (osc_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .resp_data (resp_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .tie_cnt   (tie_cnt),
    .sat_flag  (sat_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: pair selection at each gate start, response at each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (osc_en && !osc_prev) begin
        chk("clr_during_gate", {31'd0, cnt_clr}, 32'd0);
        if (sel_q.size() == 0) begin
          chk("sel_unexpected", 32'd1, 32'd0);
        end else begin
          mon_sel = sel_q.pop_front();
          chk("sel_pair", {24'd0, sel_a, sel_b}, {24'd0, mon_sel});
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_resp = exp_q.pop_front();
          chk("resp_data", {24'd0, resp_data}, {24'd0, mon_resp.data});
          chk("tie_cnt", {27'd0, tie_cnt}, {27'd0, mon_resp.tie});
          chk("sat_flag", {31'd0, sat_flag}, {31'd0, mon_resp.sat});
          $display("xfer: data=%02h tie=%0d sat=%0d", resp_data, tie_cnt, sat_flag);
        end
      end
      osc_prev = osc_en;
    end else begin
      osc_prev = 1'b0;
    end
  end

  task automatic set_tables(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      ca_tab[i] = a;
      cb_tab[i] = b;
    end
  endtask

  task automatic push_expected(input logic [7:0] ch, output resp_t r);
    logic [3:0] sa;
    logic [3:0] off;
    r   = '0;
    off = (ch[7:4] == 4'd0) ? 4'd1 : ch[7:4];
    for (int k = 0; k < 8; k++) begin
      sa = ch[3:0] + 4'(k);
      sel_q.push_back({sa, 4'(sa + off)});
      if (ca_tab[k] > cb_tab[k]) r.data[k] = 1'b1;
      if (ca_tab[k] == cb_tab[k]) r.tie = r.tie + 5'd1;
      if (ca_tab[k] == 16'hFFFF || cb_tab[k] == 16'hFFFF) r.sat = 1'b1;
    end
    exp_q.push_back(r);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_osc_en"}, {31'd0, osc_en}, 32'd0);
    chk({tag, "_cnt_clr"}, {31'd0, cnt_clr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, resp_data}, 32'd0);
    chk({tag, "_tie"}, {27'd0, tie_cnt}, 32'd0);
    chk({tag, "_sat"}, {31'd0, sat_flag}, 32'd0);
    chk({tag, "_sel"}, {24'd0, sel_a, sel_b}, 32'd0);
  endtask

  // One full run; hold > 0 keeps resp_ready low that many cycles after valid
  // and pokes start while busy.  Called at posedge+1.
  task automatic do_run(input logic [7:0] ch, input int hold);
    resp_t r;
    int    n;
    cur_base = ch[3:0];
    push_expected(ch, r);
    $display("run: challenge=%02h expect data=%02h tie=%0d sat=%0d", ch, r.data, r.tie, r.sat);
    resp_ready = (hold == 0);
    challenge  = ch;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("sat_cleared_on_start", {31'd0, sat_flag}, 32'd0);
    chk("data_cleared_on_start", {24'd0, resp_data}, 32'd0);
    while (!resp_valid && n < 20000) begin
      if (hold > 0 && n == 100) start = 1'b1;
      if (hold > 0 && n == 101) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, LAT);
    for (int i = 0; i < hold; i++) begin
      if (i == 10) start = 1'b1;
      if (i == 11) start = 1'b0;
      if (i % 10 == 0) begin
        chk("valid_held", {31'd0, resp_valid}, 32'd1);
        chk("data_held", {24'd0, resp_data}, {24'd0, r.data});
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_after_xfer", {31'd0, resp_valid}, 32'd0);
    chk("idle_after_xfer", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resp_t r;
    int    n;
    set_tables(16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b0;
    @(posedge clk); #1;

    // All bank-A counts higher
    set_tables(16'd500, 16'd400);
    do_run(8'h30, 0);

    // Zero offset forced to 1, selects wrap, bank A always lower
    set_tables(16'd100, 16'd200);
    do_run(8'h0E, 0);

    // Ties on pairs 2 and 5
    set_tables(16'd600, 16'd500);
    ca_tab[2] = 16'd1234; cb_tab[2] = 16'd1234;
    ca_tab[5] = 16'd1234; cb_tab[5] = 16'd1234;
    do_run(8'h21, 0);

    // Saturated bank-B count on pair 4, consumer stalls, start poked while busy
    set_tables(16'd500, 16'd400);
    cb_tab[4] = 16'hFFFF;
    do_run(8'h93, 50);

    // sat_flag must clear on the next run
    set_tables(16'd500, 16'd400);
    do_run(8'h55, 0);

    // Reset during the gate of pair 3
    set_tables(16'd700, 16'd300);
    cur_base = 4'hA;
    push_expected(8'h7A, r);
    challenge = 8'h7A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(osc_en && sel_a == 4'hD) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_gate_k3", {31'd0, osc_en}, 32'd1);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    sel_q.delete();
    #1;
    check_reset_values("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Full run after the reset, mixed counts with likely ties
    for (int i = 0; i < 16; i++) begin
      ca_tab[i] = 16'(1000 + $urandom_range(0, 3));
      cb_tab[i] = 16'(1000 + $urandom_range(0, 3));
    end
    do_run(8'h7A, 0);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("sel_queue_drained", sel_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
